// File: rtl/gen_dac_serializer_if.sv
// Sample-side bus between the function generator and the DAC serializer:
// the write strobe and data, plus the FIFO status that is reported back.
interface gen_dac_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  full_o;
  logic                  empty_o;
  logic [LVL_W-1:0]      level_o;
  logic                  overflow_o;

  modport master (
    output wr_en_i, data_i,
    input  full_o, empty_o, level_o, overflow_o
  );

  modport slave (
    input  wr_en_i, data_i,
    output full_o, empty_o, level_o, overflow_o
  );
endinterface

// File: rtl/gen_dac_serializer.sv
// Sample FIFO drained MSB-first over a 3-wire DAC link (sclk_o/cs_n_o/sdo_o).
// Optional macro OFFSET_BINARY_EN: invert the sample MSB at LOAD (offset binary).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no frame; cs_n high, sclk low; waits for en_i && !empty
// S_LOAD  | pops FIFO head into the shift register, drops cs_n
// S_SHIFT | toggles sclk every CLK_DIV clocks, 16 rising edges/frame
// S_GAP   | cs_n high for CS_GAP clocks before the next frame
module gen_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gen_dac_serializer_if.slave  smp,
  input  logic                 en_i,
  output logic                 busy_o,
  output logic                 sclk_o,
  output logic                 cs_n_o,
  output logic                 sdo_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;

  logic                  push, pop, drop;
  logic [DATA_WIDTH-1:0] head, head_mod;

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  always_comb begin
    pop  = (state_q == S_LOAD);
    push = smp.wr_en_i && (!full_q || pop);
    drop = smp.wr_en_i && full_q && !pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    full_d     = (count_d == LVL_W'(FIFO_DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | drop;
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
`ifdef OFFSET_BINARY_EN
    head_mod = {~head[DATA_WIDTH-1], head[DATA_WIDTH-2:0]};
`else
    head_mod = head;
`endif
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    sdo_d     = sdo_q;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (en_i && !empty_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d   = head_mod;
        bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
        div_cnt_d = '0;
        cs_n_d    = 1'b0;
        sdo_d     = head_mod[DATA_WIDTH-1];
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Data only moves on the falling edge so it is stable at the DAC's rising edge.
          if (sclk_q) begin
            if (bit_cnt_q != '0) begin
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              sdo_d     = shift_q[DATA_WIDTH-2];
              bit_cnt_d = bit_cnt_q - BIT_W'(1);
            end else begin
              cs_n_d    = 1'b1;
              sdo_d     = 1'b0;
              gap_cnt_d = GAP_W'(CS_GAP - 1);
              state_d   = S_GAP;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        cs_n_d = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = (en_i && !empty_q) ? S_LOAD : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= smp.data_i;
  end

  assign smp.full_o     = full_q;
  assign smp.empty_o    = empty_q;
  assign smp.level_o    = count_q;
  assign smp.overflow_o = overflow_q;
  assign busy_o         = busy_q;
  assign sclk_o         = sclk_q;
  assign cs_n_o         = cs_n_q;
  assign sdo_o          = sdo_q;

endmodule

// File: tb/tb_gen_dac_serializer.sv
// Directed bench for gen_dac_serializer: FIFO fill table plus frame-level sequences.
// Frame expectations follow OFFSET_BINARY_EN when it is defined for the build.
module tb_gen_dac_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_i = 1'b0;
  logic busy_o, sclk_o, cs_n_o, sdo_o;

  int n_total = 0;
  int n_pass  = 0;

  gen_dac_serializer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) smp ();

  gen_dac_serializer #(
    .DATA_WIDTH(16), .FIFO_DEPTH(8), .CLK_DIV(2), .CS_GAP(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .smp    (smp),
    .en_i   (en_i),
    .busy_o (busy_o),
    .sclk_o (sclk_o),
    .cs_n_o (cs_n_o),
    .sdo_o  (sdo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    smp.wr_en_i = 1'b0;
    en_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write(input logic [15:0] d);
    smp.wr_en_i = 1'b1;
    smp.data_i  = d;
    tick();
    smp.wr_en_i = 1'b0;
  endtask

  // Captures sdo at each sclk rise while cs_n is low; optionally drops en_i after N rises.
  task automatic run_frame(input int drop_after, output logic [15:0] word,
                           output int rises, output int low_cycles);
    logic prev;
    word = '0; rises = 0; low_cycles = 0;
    for (int t = 0; t < 20 && cs_n_o; t++) tick();
    if (cs_n_o) begin
      check("cs_fall_timeout", 32'(cs_n_o), 32'd0);
      return;
    end
    prev = sclk_o;
    while (!cs_n_o && low_cycles < 200) begin
      if (sclk_o && !prev) begin
        word = {word[14:0], sdo_o};
        rises++;
        if (rises == drop_after) en_i = 1'b0;
      end
      prev = sclk_o;
      tick();
      low_cycles++;
    end
  endtask

  logic [15:0] word;
  logic [15:0] exp_a, exp_b;
  int rises, low_cycles, bad;
  logic prev;

  initial begin
    vecs[0] = '{1'b1, 16'h1111, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h2222, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h3333, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h4444, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h5555, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h6666, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h7777, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h8888, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h9999, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 4'd8, 1'b1, 1'b0, 1'b1};

    smp.wr_en_i = 1'b0;
    smp.data_i  = '0;

    // Reset values
    tick(); tick(); tick();
    check("rst_full",     32'(smp.full_o),     32'd0);
    check("rst_empty",    32'(smp.empty_o),    32'd1);
    check("rst_level",    32'(smp.level_o),    32'd0);
    check("rst_overflow", 32'(smp.overflow_o), 32'd0);
    check("rst_busy",     32'(busy_o),         32'd0);
    check("rst_sclk",     32'(sclk_o),         32'd0);
    check("rst_cs_n",     32'(cs_n_o),         32'd1);
    check("rst_sdo",      32'(sdo_o),          32'd0);
    rst = 1'b1;
    en_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sclk_o || !cs_n_o || busy_o) bad++;
    end
    check("idle_when_empty", 32'(bad), 32'd0);

    // Single frame A5C3: latency, bit order, frame length, gap
    write(16'hA5C3);
    check("cs_high_t1", 32'(cs_n_o), 32'd1);
    tick();
    check("cs_high_t2", 32'(cs_n_o), 32'd1);
    tick();
    check("cs_low_t3", 32'(cs_n_o), 32'd0);
    check("busy_in_frame", 32'(busy_o), 32'd1);
    run_frame(0, word, rises, low_cycles);
    check("a5c3_bits",  32'(word),       32'h0000A5C3);
    check("a5c3_rises", 32'(rises),      32'd16);
    check("a5c3_low",   32'(low_cycles), 32'd64);
    check("a5c3_sdo_idle", 32'(sdo_o),   32'd0);
    tick();
    check("busy_in_gap", 32'(busy_o), 32'd1);
    tick();
    check("busy_after_gap", 32'(busy_o), 32'd0);
    check("empty_after_frame", 32'(smp.empty_o), 32'd1);

    // FIFO fill and overflow table, serializer disabled
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp.wr_en_i = vecs[i].wr;
      smp.data_i  = vecs[i].data;
      tick();
      check($sformatf("fill%0d_level", i),    32'(smp.level_o),    32'(vecs[i].level));
      check($sformatf("fill%0d_full", i),     32'(smp.full_o),     32'(vecs[i].full));
      check($sformatf("fill%0d_empty", i),    32'(smp.empty_o),    32'(vecs[i].empty));
      check($sformatf("fill%0d_overflow", i), 32'(smp.overflow_o), 32'(vecs[i].overflow));
    end
    smp.wr_en_i = 1'b0;
    check("no_frame_when_disabled", 32'(busy_o), 32'd0);
    // The 9th sample was dropped: the first frame drains the oldest one
    en_i = 1'b1;
    run_frame(0, word, rises, low_cycles);
    check("fifo_order_head", 32'(word), 32'h00001111);
    check("overflow_sticky", 32'(smp.overflow_o), 32'd1);

    // en_i dropped during frame 1: frame completes, no frame 2
    do_reset();
    write(16'hC0DE);
    write(16'h1234);
    write(16'h5678);
    en_i = 1'b1;
    run_frame(5, word, rises, low_cycles);
    check("drop_en_bits",  32'(word),  32'h0000C0DE);
    check("drop_en_rises", 32'(rises), 32'd16);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!cs_n_o || sclk_o) bad++;
    end
    check("drop_en_no_frame2", 32'(bad), 32'd0);
    check("drop_en_busy",  32'(busy_o),      32'd0);
    check("drop_en_level", 32'(smp.level_o), 32'd2);

    // Async reset in the middle of a frame
    do_reset();
    write(16'hFFFF);
    en_i = 1'b1;
    rises = 0;
    prev = sclk_o;
    for (int t = 0; t < 200 && rises < 8; t++) begin
      tick();
      if (sclk_o && !prev) rises++;
      prev = sclk_o;
    end
    check("mid_reach_bit8", 32'(rises), 32'd8);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_cs_n",  32'(cs_n_o),        32'd1);
    check("mid_rst_sclk",  32'(sclk_o),        32'd0);
    check("mid_rst_sdo",   32'(sdo_o),         32'd0);
    check("mid_rst_busy",  32'(busy_o),        32'd0);
    check("mid_rst_empty", 32'(smp.empty_o),   32'd1);
    check("mid_rst_level", 32'(smp.level_o),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    en_i = 1'b0;
    tick();

    // Sign-boundary samples, back-to-back frames
`ifdef OFFSET_BINARY_EN
    exp_a = 16'h0000;
    exp_b = 16'hFFFF;
`else
    exp_a = 16'h8000;
    exp_b = 16'h7FFF;
`endif
    write(16'h8000);
    write(16'h7FFF);
    en_i = 1'b1;
    run_frame(0, word, rises, low_cycles);
    check("min_neg_bits", 32'(word), 32'(exp_a));
    check("min_neg_low",  32'(low_cycles), 32'd64);
    run_frame(0, word, rises, low_cycles);
    check("max_pos_bits",  32'(word),  32'(exp_b));
    check("max_pos_rises", 32'(rises), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
